// File: rtl/fxp_mac_sat.sv
// fxp_mac_sat: two-stage signed fixed-point multiply / multiply-accumulate
// with round-half-up and saturation to W bits.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   beat qualifier for x1, x2, mode, in_last
//   x1, x2     signed W-bit operands (FRAC fractional bits)
//   mode       0 = single multiply, 1 = accumulate into the running group
//   in_last    closes an accumulate group (ignored when mode = 0)
//   out_valid  one-cycle pulse marking a new result
//   dout       signed W-bit result, held between pulses
//   ovf        saturation happened somewhere in this result
//   cnt        number of beats folded into this result
module fxp_mac_sat #(
  parameter int W     = 8,
  parameter int FRAC  = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [W-1:0]     x1,
  input  logic [W-1:0]     x2,
  input  logic             mode,
  input  logic             in_last,
  output logic             out_valid,
  output logic [W-1:0]     dout,
  output logic             ovf,
  output logic [CNT_W-1:0] cnt
);

  localparam logic signed [2*W:0] HALF  = (2*W+1)'(1) << (FRAC-1);
  localparam logic signed [2*W:0] MAX_V = {{(W+2){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W:0] MIN_V = {{(W+2){1'b1}}, {(W-1){1'b0}}};

  // Round to nearest, ties toward +inf; one guard bit keeps the add exact.
  function automatic logic signed [2*W:0] round_prod(input logic signed [2*W-1:0] p);
    logic signed [2*W:0] ext;
    ext = {p[2*W-1], p} + HALF;
    return ext >>> FRAC;
  endfunction

  // Returns {sat_flag, clamped W-bit value}.
  function automatic logic [W:0] sat_w(input logic signed [2*W:0] v);
    if (v > MAX_V)      return {1'b1, MAX_V[W-1:0]};
    else if (v < MIN_V) return {1'b1, MIN_V[W-1:0]};
    else                return {1'b0, v[W-1:0]};
  endfunction

  // ---- stage 1: full-precision product ----
  logic                  vld_p1;
  logic                  mode_p1;
  logic                  last_p1;
  logic signed [2*W-1:0] prod_p1;

  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (in_valid) begin
      prod_p1 <= $signed(x1) * $signed(x2);
      mode_p1 <= mode;
      last_p1 <= in_last;
    end
  end

  // ---- stage 2: round, saturate, accumulate, register result ----
  logic signed [2*W:0]   rnd_p1;
  logic signed [W-1:0]   prod_sat;
  logic                  sat_prod;
  logic signed [2*W:0]   sum_ext;
  logic signed [W-1:0]   sum_sat;
  logic                  sat_sum;
  logic [CNT_W-1:0]      cnt_inc;

  logic signed [W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]      grp_cnt_q, grp_cnt_d;
  logic                  ovf_acc_q, ovf_acc_d;
  logic                  vld_p2, vld_d;
  logic signed [W-1:0]   dout_p2, dout_d;
  logic                  ovf_p2, ovf_d;
  logic [CNT_W-1:0]      cnt_p2, cnt_d;

  assign rnd_p1                = round_prod(prod_p1);
  assign {sat_prod, prod_sat}  = sat_w(rnd_p1);
  assign sum_ext               = {{(W+1){acc_q[W-1]}}, acc_q}
                               + {{(W+1){prod_sat[W-1]}}, prod_sat};
  assign {sat_sum, sum_sat}    = sat_w(sum_ext);
  assign cnt_inc               = (grp_cnt_q == {CNT_W{1'b1}}) ? grp_cnt_q
                                                               : grp_cnt_q + CNT_W'(1);

  always_comb begin
    acc_d     = acc_q;
    grp_cnt_d = grp_cnt_q;
    ovf_acc_d = ovf_acc_q;
    vld_d     = 1'b0;
    dout_d    = dout_p2;
    ovf_d     = ovf_p2;
    cnt_d     = cnt_p2;
    if (vld_p1) begin
      if (!mode_p1) begin
        // Single multiply leaves any open group untouched.
        vld_d  = 1'b1;
        dout_d = prod_sat;
        ovf_d  = sat_prod;
        cnt_d  = CNT_W'(1);
      end else if (last_p1) begin
        vld_d     = 1'b1;
        dout_d    = sum_sat;
        ovf_d     = ovf_acc_q | sat_prod | sat_sum;
        cnt_d     = cnt_inc;
        acc_d     = '0;
        grp_cnt_d = '0;
        ovf_acc_d = 1'b0;
      end else begin
        acc_d     = sum_sat;
        grp_cnt_d = cnt_inc;
        ovf_acc_d = ovf_acc_q | sat_prod | sat_sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      grp_cnt_q <= '0;
      ovf_acc_q <= 1'b0;
      vld_p2    <= 1'b0;
      dout_p2   <= '0;
      ovf_p2    <= 1'b0;
      cnt_p2    <= '0;
    end else begin
      acc_q     <= acc_d;
      grp_cnt_q <= grp_cnt_d;
      ovf_acc_q <= ovf_acc_d;
      vld_p2    <= vld_d;
      dout_p2   <= dout_d;
      ovf_p2    <= ovf_d;
      cnt_p2    <= cnt_d;
    end
  end

  assign out_valid = vld_p2;
  assign dout      = dout_p2;
  assign ovf       = ovf_p2;
  assign cnt       = cnt_p2;

endmodule

// File: tb/tb_fxp_mac_sat.sv
// tb_fxp_mac_sat: directed and randomized checks of fxp_mac_sat (W=8, FRAC=4)
// against a plain-arithmetic reference model.
module tb_fxp_mac_sat;

  localparam int W     = 8;
  localparam int FRAC  = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [W-1:0]     x1 = '0;
  logic [W-1:0]     x2 = '0;
  logic             mode = 1'b0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic [W-1:0]     dout;
  logic             ovf;
  logic [CNT_W-1:0] cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  // monitor capture used by group tests
  int          pulses;
  logic [17:0] cap [0:3];

  fxp_mac_sat #(.W(W), .FRAC(FRAC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .x1(x1), .x2(x2),
    .mode(mode), .in_last(in_last), .out_valid(out_valid), .dout(dout),
    .ovf(ovf), .cnt(cnt)
  );

  always #5 clk = ~clk;

  // ---------------- reference model helpers ----------------
  function automatic int clamp8(input int v);
    if (v > 127)  return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  // real-valued product scaled by 2^-FRAC, rounded half up
  function automatic int mul_round(input int a, input int b);
    real r;
    r = real'(a * b) / real'(1 << FRAC);
    return $rtoi($floor(r + 0.5));
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic set_in(input logic v, input logic [7:0] a, input logic [7:0] b,
                        input logic m, input logic l);
    in_valid = v; x1 = a; x2 = b; mode = m; in_last = l;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic tick_mon();
    @(posedge clk); #1;
    if (out_valid) begin
      if (pulses < 4) cap[pulses] = {out_valid, dout, ovf, cnt};
      pulses++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [17:0] got;
    rst = 1'b1;
    set_in(1'b1, 8'h70, 8'h70, 1'b0, 1'b0);
    repeat (3) tick();
    got = {out_valid, dout, ovf, cnt};
    n_cmp++;
    if (got !== 18'h0) begin
      n_fail++;
      $display("FAIL reset_state: got %h want %h", got, 18'h0);
    end
    // beat presented in the first cycle after reset releases must be taken
    rst = 1'b0;
    set_in(1'b1, 8'h10, 8'h10, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flushed: out_valid %b want 0", out_valid);
    end
    tick();
    got = {out_valid, dout, ovf, cnt};
    n_cmp++;
    if (got !== {1'b1, 8'h10, 1'b0, 8'd1}) begin
      n_fail++;
      $display("FAIL first_after_reset: got %h want %h", got, {1'b1, 8'h10, 1'b0, 8'd1});
    end
    tick();
  endtask

  task automatic test_single();
    logic [17:0] got;
    set_in(1'b1, 8'h10, 8'h10, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_latency: out_valid %b one cycle after beat, want 0", out_valid);
    end
    tick();
    got = {out_valid, dout, ovf, cnt};
    n_cmp++;
    if (got !== {1'b1, 8'h10, 1'b0, 8'd1}) begin
      n_fail++;
      $display("FAIL single_result: got %h want %h", got, {1'b1, 8'h10, 1'b0, 8'd1});
    end
    tick();
    got = {out_valid, dout, ovf, cnt};
    n_cmp++;
    if (got !== {1'b0, 8'h10, 1'b0, 8'd1}) begin
      n_fail++;
      $display("FAIL single_hold: got %h want %h", got, {1'b0, 8'h10, 1'b0, 8'd1});
    end
  endtask

  // back-to-back beats through a table; one result per cycle expected
  task automatic run_table(input string name, input logic [7:0] a [0:3],
                           input logic [7:0] b [0:3], input logic [7:0] e [0:3],
                           input logic eo, input int n);
    logic [17:0] got, want;
    for (int i = 0; i <= n; i++) begin
      if (i < n) set_in(1'b1, a[i], b[i], 1'b0, 1'b0);
      else       set_in(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      tick();
      if (i > 0) begin
        got  = {out_valid, dout, ovf, cnt};
        want = {1'b1, e[i-1], eo, 8'd1};
        n_cmp++;
        if (got !== want) begin
          n_fail++;
          $display("FAIL %s[%0d]: got %h want %h", name, i-1, got, want);
        end
      end
    end
    tick();
  endtask

  task automatic test_rounding();
    logic [7:0] a [0:3] = '{8'h08, 8'h08, 8'hF8, 8'h00};
    logic [7:0] b [0:3] = '{8'h09, 8'h07, 8'hF9, 8'h00};
    logic [7:0] e [0:3] = '{8'h05, 8'h04, 8'h04, 8'h00};
    run_table("rounding", a, b, e, 1'b0, 3);
  endtask

  task automatic test_saturation();
    logic [7:0] a [0:3] = '{8'h70, 8'h90, 8'h80, 8'h60};
    logic [7:0] b [0:3] = '{8'h70, 8'h90, 8'h70, 8'h60};
    logic [7:0] e [0:3] = '{8'h7F, 8'h7F, 8'h80, 8'h7F};
    run_table("saturation", a, b, e, 1'b1, 4);
  endtask

  task automatic test_accumulate();
    pulses = 0;
    set_in(1'b1, 8'h10, 8'h10, 1'b1, 1'b0); tick_mon();
    set_in(1'b0, 8'h00, 8'h00, 1'b1, 1'b0); tick_mon();
    set_in(1'b1, 8'h20, 8'h10, 1'b1, 1'b0); tick_mon();
    set_in(1'b1, 8'h30, 8'h10, 1'b1, 1'b1); tick_mon();
    set_in(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    repeat (3) tick_mon();
    n_cmp++;
    if (pulses !== 1) begin
      n_fail++;
      $display("FAIL acc_pulses: got %0d want 1", pulses);
    end
    n_cmp++;
    if (pulses >= 1 && cap[0] !== {1'b1, 8'h60, 1'b0, 8'd3}) begin
      n_fail++;
      $display("FAIL acc_result: got %h want %h", cap[0], {1'b1, 8'h60, 1'b0, 8'd3});
    end
  endtask

  task automatic test_acc_sat();
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 8'h30, 8'h10, 1'b1, (i == 3));
      tick_mon();
    end
    set_in(1'b1, 8'h10, 8'h10, 1'b1, 1'b1); tick_mon();
    set_in(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    repeat (3) tick_mon();
    n_cmp++;
    if (pulses !== 2) begin
      n_fail++;
      $display("FAIL accsat_pulses: got %0d want 2", pulses);
    end
    n_cmp++;
    if (cap[0] !== {1'b1, 8'h7F, 1'b1, 8'd4}) begin
      n_fail++;
      $display("FAIL accsat_group1: got %h want %h", cap[0], {1'b1, 8'h7F, 1'b1, 8'd4});
    end
    n_cmp++;
    if (cap[1] !== {1'b1, 8'h10, 1'b0, 8'd1}) begin
      n_fail++;
      $display("FAIL accsat_group2: got %h want %h", cap[1], {1'b1, 8'h10, 1'b0, 8'd1});
    end
  endtask

  task automatic test_reset_mid_group();
    pulses = 0;
    set_in(1'b1, 8'h30, 8'h10, 1'b1, 1'b0); tick_mon();
    set_in(1'b1, 8'h30, 8'h10, 1'b1, 1'b0); tick_mon();
    rst = 1'b1;
    set_in(1'b0, 8'h00, 8'h00, 1'b0, 1'b0); tick_mon();
    rst = 1'b0;
    n_cmp++;
    if (pulses !== 0 || {out_valid, dout, ovf, cnt} !== 18'h0) begin
      n_fail++;
      $display("FAIL rstmid_cleared: pulses %0d outputs %h want 0 / 0",
               pulses, {out_valid, dout, ovf, cnt});
    end
    set_in(1'b1, 8'h10, 8'h10, 1'b1, 1'b1); tick_mon();
    set_in(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    repeat (3) tick_mon();
    n_cmp++;
    if (pulses !== 1 || cap[0] !== {1'b1, 8'h10, 1'b0, 8'd1}) begin
      n_fail++;
      $display("FAIL rstmid_newgroup: pulses %0d got %h want 1 / %h",
               pulses, cap[0], {1'b1, 8'h10, 1'b0, 8'd1});
    end
  endtask

  task automatic test_random();
    int macc, mcnt, pd, pc, cd, cc, ld, lc, a, b, r, s, ncnt;
    bit mov, po, co, lo, ph, ch, sp, ss;
    logic [17:0] got, want;
    logic v, m, l, rr;
    logic [7:0] ua, ub;
    rst = 1'b1; set_in(1'b0, 8'h00, 8'h00, 1'b0, 1'b0); tick(); rst = 1'b0;
    macc = 0; mcnt = 0; mov = 0;
    ph = 0; pd = 0; po = 0; pc = 0;
    ld = 0; lo = 0; lc = 0;
    for (int t = 0; t < 600; t++) begin
      rr = ($urandom_range(0, 49) == 0);
      v  = ($urandom_range(0, 4) != 0);
      m  = ($urandom_range(0, 3) != 0);
      l  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 0) begin
        ua = 8'($urandom); ub = 8'($urandom);
      end else begin
        ua = 8'($urandom_range(0, 63) - 32); ub = 8'($urandom_range(0, 63) - 32);
      end
      rst = rr;
      set_in(v, ua, ub, m, l);
      ch = 0; cd = 0; co = 0; cc = 0;
      if (rr) begin
        macc = 0; mcnt = 0; mov = 0;
      end else if (v) begin
        a  = int'($signed(ua));
        b  = int'($signed(ub));
        r  = clamp8(mul_round(a, b));
        sp = (r != mul_round(a, b));
        if (!m) begin
          ch = 1; cd = r; co = sp; cc = 1;
        end else begin
          s    = clamp8(macc + r);
          ss   = (s != macc + r);
          ncnt = (mcnt >= 255) ? 255 : mcnt + 1;
          if (l) begin
            ch = 1; cd = s; co = mov | sp | ss; cc = ncnt;
            macc = 0; mcnt = 0; mov = 0;
          end else begin
            macc = s; mcnt = ncnt; mov = mov | sp | ss;
          end
        end
      end
      tick();
      if (rr) begin
        want = 18'h0;
        ld = 0; lo = 0; lc = 0;
      end else if (ph) begin
        want = {1'b1, 8'(pd), po, 8'(pc)};
        ld = pd; lo = po; lc = pc;
      end else begin
        want = {1'b0, 8'(ld), lo, 8'(lc)};
      end
      got = {out_valid, dout, ovf, cnt};
      n_cmp++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL random[%0d]: got %h want %h", t, got, want);
      end
      ph = ch; pd = cd; po = co; pc = cc;
    end
    rst = 1'b0;
    set_in(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    repeat (2) tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_rounding();
    test_saturation();
    test_accumulate();
    test_acc_sat();
    test_reset_mid_group();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
